calc_sequencer: RTL and testbench

//   Transaction controller for the 4-bit Calculator ALU. Accepts one operation per

---
 rtl/calc_sequencer.sv | 148 ++++++++++++++
 tb/tb_calc_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/calc_sequencer.sv
// Transaction controller for the 4-bit calculator ALU.
// It latches one request, holds the operands on the ALU for a settle time,
// then registers the 8-bit result and holds it until the consumer takes it.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | ready for a request; in_ready=1
//   EXEC  | operands latched, settle counter running down to zero
//   DONE  | result/div_err held, out_valid=1 until out_ready
module calc_sequencer #(
  parameter int EXEC_CYCLES = 1,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       a,
  input  logic [3:0]       b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       result,
  output logic             div_err,
  output logic [CNT_W-1:0] op_count
);

  // A zero settle time still needs one edge for the ALU to see the latched operands.
  localparam int EXEC_EFF = (EXEC_CYCLES < 1) ? 1 : EXEC_CYCLES;
  localparam int WAIT_W   = (EXEC_EFF > 1) ? $clog2(EXEC_EFF) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(EXEC_EFF - 1);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_NOT  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;
  localparam logic [2:0] OP_MULT = 3'b110;
  localparam logic [2:0] OP_DIV  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [WAIT_W-1:0]   r_wait;
  logic [3:0]          r_a;
  logic [3:0]          r_b;
  logic [2:0]          r_op;
  logic [7:0]          r_result;
  logic                r_div_err;
  logic [CNT_W-1:0]    r_op_count;
  logic [7:0]          w_alu;
  logic                w_div_zero;
  logic                w_accept;
  logic                w_capture;
  logic                w_release;

  assign w_accept  = (r_state == IDLE) && in_valid;
  assign w_capture = (r_state == EXEC) && (r_wait == '0);
  assign w_release = (r_state == DONE) && out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_next = EXEC;
      EXEC:    if (w_capture) w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Operand latch and settle down-counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_op   <= '0;
      r_wait <= '0;
    end else if (w_accept) begin
      r_a    <= a;
      r_b    <= b;
      r_op   <= op;
      r_wait <= WAIT_LOAD;
    end else if ((r_state == EXEC) && (r_wait != '0)) begin
      r_wait <= r_wait - 1'b1;
    end
  end

  // ALU, driven only from the latched operands; results are 8-bit two's complement
  always_comb begin
    w_alu      = 8'h00;
    w_div_zero = 1'b0;
    case (r_op)
      OP_AND:  w_alu = {4'h0, r_a & r_b};
      OP_OR:   w_alu = {4'h0, r_a | r_b};
      OP_NOT:  w_alu = ~{4'h0, r_a};
      OP_XOR:  w_alu = {4'h0, r_a ^ r_b};
      OP_ADD:  w_alu = {4'h0, r_a} + {4'h0, r_b};
      OP_SUB:  w_alu = {4'h0, r_a} - {4'h0, r_b};
      OP_MULT: w_alu = {4'h0, r_a} * {4'h0, r_b};
      OP_DIV: begin
        if (r_b == 4'h0) begin
          w_alu      = 8'hFF;
          w_div_zero = 1'b1;
        end else begin
          w_alu = {4'h0, r_a / r_b};
        end
      end
      default: w_alu = 8'h00;
    endcase
  end

  // Result capture at the end of the settle time; held until the next capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result  <= 8'h00;
      r_div_err <= 1'b0;
    end else if (w_capture) begin
      r_result  <= w_alu;
      r_div_err <= w_div_zero;
    end
  end

  // Completed-operation counter, advanced when the consumer takes a result
  always_ff @(posedge clk) begin
    if (rst)            r_op_count <= '0;
    else if (w_release) r_op_count <= r_op_count + 1'b1;
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign result    = r_result;
  assign div_err   = r_div_err;
  assign op_count  = r_op_count;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer: default build, a 4-cycle settle build
// and a 2-bit counter build, all driven from one linear sequence.
module tb_calc_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic [2:0] op = '0;

  logic       in_valid = 1'b0, out_ready = 1'b0;
  logic       in_ready, out_valid, div_err;
  logic [7:0] result;
  logic [7:0] op_count;

  logic       rst4 = 1'b1, in_valid4 = 1'b0, out_ready4 = 1'b0;
  logic       in_ready4, out_valid4, div_err4;
  logic [7:0] result4;
  logic [7:0] op_count4;

  logic       in_validc = 1'b0, out_readyc = 1'b0;
  logic       in_readyc, out_validc, div_errc;
  logic [7:0] resultc;
  logic [1:0] op_countc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  calc_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .div_err(div_err), .op_count(op_count)
  );

  calc_sequencer #(.EXEC_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst4), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a), .b(b), .op(op), .out_valid(out_valid4), .out_ready(out_ready4),
    .result(result4), .div_err(div_err4), .op_count(op_count4)
  );

  calc_sequencer #(.CNT_W(2)) dutc (
    .clk(clk), .rst(rst), .in_valid(in_validc), .in_ready(in_readyc),
    .a(a), .b(b), .op(op), .out_valid(out_validc), .out_ready(out_readyc),
    .result(resultc), .div_err(div_errc), .op_count(op_countc)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    tick();
    tick();
    rst  = 1'b0;
    rst4 = 1'b0;

    // reset state
    chk("rst_in_ready", {7'd0, in_ready}, 8'h01);
    chk("rst_out_valid", {7'd0, out_valid}, 8'h00);
    chk("rst_result", result, 8'h00);
    chk("rst_div_err", {7'd0, div_err}, 8'h00);
    chk("rst_op_count", op_count, 8'h00);

    // 1: ADD 9+8
    a = 4'd9; b = 4'd8; op = 3'b100; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("add_exec_in_ready", {7'd0, in_ready}, 8'h00);
    chk("add_exec_out_valid", {7'd0, out_valid}, 8'h00);
    tick();
    chk("add_out_valid", {7'd0, out_valid}, 8'h01);
    chk("add_result", result, 8'h11);
    chk("add_div_err", {7'd0, div_err}, 8'h00);
    tick();
    chk("add_idle", {7'd0, in_ready}, 8'h01);
    chk("add_op_count", op_count, 8'h01);

    // 2: SUB 3-5, operands disturbed during EXEC
    a = 4'd3; b = 4'd5; op = 3'b101; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; a = 4'd0; b = 4'd0; op = 3'b000;
    tick();
    chk("sub_out_valid", {7'd0, out_valid}, 8'h01);
    chk("sub_result", result, 8'hFE);
    tick();
    chk("sub_op_count", op_count, 8'h02);

    // 3: DIV by zero, then DIV 9/2
    a = 4'd7; b = 4'd0; op = 3'b111; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("div0_result", result, 8'hFF);
    chk("div0_err", {7'd0, div_err}, 8'h01);
    tick();
    chk("div0_result_held", result, 8'hFF);
    a = 4'd9; b = 4'd2; op = 3'b111; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("div_result", result, 8'h04);
    chk("div_err_clr", {7'd0, div_err}, 8'h00);
    tick();
    chk("div_op_count", op_count, 8'h04);

    // 4: MULT 15*15 with consumer stalled
    a = 4'd15; b = 4'd15; op = 3'b110; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      a = 4'(i); b = 4'(i + 1); op = 3'b100;
      chk("mult_hold_valid", {7'd0, out_valid}, 8'h01);
      chk("mult_hold_result", result, 8'hE1);
      chk("mult_hold_in_ready", {7'd0, in_ready}, 8'h00);
      chk("mult_hold_count", op_count, 8'h04);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("mult_still_done", {7'd0, out_valid}, 8'h01);
    tick();
    chk("mult_idle", {7'd0, in_ready}, 8'h01);
    chk("mult_op_count", op_count, 8'h05);
    tick();
    chk("mult_no_spurious", {7'd0, out_valid}, 8'h00);
    chk("mult_result_kept", result, 8'hE1);

    // 5: EXEC_CYCLES=4 latency, then reset during EXEC
    a = 4'd2; b = 4'd3; op = 3'b100; in_valid4 = 1'b1; out_ready4 = 1'b1;
    tick();
    in_valid4 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("e4_wait_valid", {7'd0, out_valid4}, 8'h00);
      tick();
    end
    chk("e4_wait_last", {7'd0, out_valid4}, 8'h00);
    tick();
    chk("e4_out_valid", {7'd0, out_valid4}, 8'h01);
    chk("e4_result", result4, 8'h05);
    tick();
    chk("e4_op_count", op_count4, 8'h01);
    a = 4'd7; b = 4'd1; op = 3'b100; in_valid4 = 1'b1;
    tick();
    in_valid4 = 1'b0;
    chk("e4r_exec1", {7'd0, in_ready4}, 8'h00);
    tick();
    rst4 = 1'b1;
    chk("e4r_exec2", {7'd0, out_valid4}, 8'h00);
    tick();
    rst4 = 1'b0;
    chk("e4r_idle", {7'd0, in_ready4}, 8'h01);
    chk("e4r_out_valid", {7'd0, out_valid4}, 8'h00);
    chk("e4r_result", result4, 8'h00);
    chk("e4r_op_count", op_count4, 8'h00);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("e4r_never_valid", {7'd0, out_valid4}, 8'h00);
    end

    // 6: CNT_W=2, logic ops back to back, counter wraps
    a = 4'hA; b = 4'h6; out_readyc = 1'b1;
    begin
      logic [7:0] exp_res [4];
      logic [1:0] exp_cnt [4];
      exp_res[0] = 8'h02; exp_res[1] = 8'h0E; exp_res[2] = 8'hF5; exp_res[3] = 8'h0C;
      exp_cnt[0] = 2'd1;  exp_cnt[1] = 2'd2;  exp_cnt[2] = 2'd3;  exp_cnt[3] = 2'd0;
      for (int i = 0; i < 4; i++) begin
        op = 3'(i); in_validc = 1'b1;
        tick();
        in_validc = 1'b0;
        tick();
        chk("cw_valid", {7'd0, out_validc}, 8'h01);
        chk("cw_result", resultc, exp_res[i]);
        tick();
        chk("cw_op_count", {6'd0, op_countc}, {6'd0, exp_cnt[i]});
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
